vector_stream_loader: RTL and testbench
=======================================

VECTOR_STREAM_LOADER -- requirements
Module: vector_stream_loader

Interface
REQ-001 SHALL have parameter LENGTH, default 64, meaning vector elements per bank.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning bits per element.
REQ-003 SHALL have parameter PARALLELISM, default 4, meaning elements per input beat and per write lane set.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(LENGTH), meaning element address width.
REQ-005 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin loading one vector into the inactive bank.
- swap  in  1  consumer finished with the active bank; request bank exchange.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid and s_ready are both high.
- s_data  in  PARALLELISM*DATA_WIDTH  beat; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- cfg_en  out  1  load window; steers the ping-pong bank mux to the cfg port.
- cfg_valid  out  PARALLELISM  per-lane request valid.
- cfg_write  out  PARALLELISM  per-lane write strobe.
- cfg_rready  out  PARALLELISM  per-lane read-ready; constant 0.
- cfg_addr  out  PARALLELISM*ADDR_WIDTH  per-lane element address.
- cfg_wdata  out  PARALLELISM*DATA_WIDTH  per-lane write data.
- ping  out  1  bank select toward the ping-pong stage.
- busy  out  1  high in LOAD or FULL.
- done  out  1  one-cycle pulse when the last write is presented.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, FULL.
REQ-007 IDLE: start=1 -> LOAD next cycle, with beat base counter cleared to 0.
REQ-008 IDLE: swap=1 SHALL toggle ping next cycle.
REQ-009 LOAD: s_ready SHALL be 1; in every other state s_ready SHALL be 0.
REQ-010 On an accepted beat with base B, the next cycle SHALL present for each lane i:
- cfg_addr[i] = B+i.
- cfg_wdata[i] = s_data lane i.
- cfg_valid[i] = cfg_write[i] = 1 iff B+i < LENGTH.
REQ-011 Write latency SHALL be exactly 1 cycle from handshake to cfg presentation; each write SHALL be held for 1 cycle only.
REQ-012 Cycles with no accepted beat SHALL drive cfg_valid and cfg_write all-zero; cfg_addr and cfg_wdata hold their last values.
REQ-013 Base SHALL advance by PARALLELISM per accepted beat.
REQ-014 The beat with B+PARALLELISM >= LENGTH is the last beat:
- lanes at or above LENGTH are masked.
- FSM -> FULL.
- done pulses in the cycle that beat's write is presented.
REQ-015 Number of beats per vector SHALL be ceil(LENGTH/PARALLELISM).
REQ-016 cfg_en SHALL be high from the cycle after start is accepted through the cycle the last write is presented, inclusive, and low otherwise.
REQ-017 FULL: swap=1 SHALL toggle ping and return to IDLE next cycle.
REQ-018 swap asserted during LOAD SHALL set a pending flag.
REQ-019 A pending swap SHALL be applied as a FULL swap the cycle after entering FULL (ping toggles, FSM -> IDLE), then clear.
REQ-020 start SHALL be ignored in LOAD and FULL.
REQ-021 start and swap both high in IDLE: ping SHALL toggle and LOAD SHALL be entered in the same transition.
REQ-022 ping SHALL never change while cfg_en is high.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 rst_n low SHALL asynchronously force:
- state to IDLE, ping to 0, and base and the pending flag to 0.
- cfg_en, cfg_valid, cfg_write, cfg_rready, cfg_addr, cfg_wdata to 0.
- s_ready, busy, done to 0.
REQ-025 Reset asserted mid-LOAD SHALL abort the load; no further cfg writes occur and a new start is required after release.
REQ-026 Outputs SHALL first change on the first rising clk edge after rst_n deasserts.

Verification
REQ-027 LENGTH=10, PARALLELISM=4, start, then 3 back-to-back beats:
- writes present addresses 0-3, 4-7, 8-11 with masks 1111, 1111, 0011.
- done pulses with the third write.
- cfg_en is high for 4 cycles.
REQ-028 s_valid toggling 1,0,1,0,1 in LOAD -> writes occur only the cycle after each handshake; cfg_valid is zero in gap cycles; addresses are contiguous.
REQ-029 Swap pulsed during LOAD:
- ping stays 0 until FULL.
- ping toggles to 1 the cycle after FULL is entered.
- FSM returns to IDLE.
REQ-030 Swap in IDLE with start low -> ping toggles 0->1, no cfg activity; a second swap -> ping 0.
REQ-031 rst_n low after the 2nd beat of 3 -> all outputs 0 immediately, ping 0; after release a new start reloads from address 0.
REQ-032 Start pulsed while in FULL -> ignored; s_ready stays 0 and the base does not reset.

Source files
------------

// File: rtl/vector_stream_loader.sv
// vector_stream_loader: accepts PARALLELISM-wide beats and writes one vector of
// LENGTH elements into the inactive bank of a ping-pong buffer via the cfg port.
// The bank select (ping) toggles only while no load is in progress.
//
// Handshake: a beat transfers on a rising clk edge where s_valid and s_ready are
// both high; s_ready depends only on state, never on s_valid.
module vector_stream_loader #(
  parameter int LENGTH      = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4,
  parameter int ADDR_WIDTH  = $clog2(LENGTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              swap,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [PARALLELISM*DATA_WIDTH-1:0] s_data,
  output logic                              cfg_en,
  output logic [PARALLELISM-1:0]            cfg_valid,
  output logic [PARALLELISM-1:0]            cfg_write,
  output logic [PARALLELISM-1:0]            cfg_rready,
  output logic [PARALLELISM*ADDR_WIDTH-1:0] cfg_addr,
  output logic [PARALLELISM*DATA_WIDTH-1:0] cfg_wdata,
  output logic                              ping,
  output logic                              busy,
  output logic                              done
);

  // Wide enough to hold base + PARALLELISM without wrapping.
  localparam int BASE_W = $clog2(LENGTH + PARALLELISM) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic                              r_ping;
  logic                              w_ping_nxt;
  logic                              r_pend;
  logic                              w_pend_nxt;
  logic [BASE_W-1:0]                 r_base;
  logic [BASE_W-1:0]                 w_base_nxt;
  logic                              w_fire;
  logic                              w_last;
  logic [PARALLELISM-1:0]            w_mask;
  logic [PARALLELISM*ADDR_WIDTH-1:0] w_addr;
  logic [PARALLELISM-1:0]            r_cfg_valid;
  logic [PARALLELISM*ADDR_WIDTH-1:0] r_cfg_addr;
  logic [PARALLELISM*DATA_WIDTH-1:0] r_cfg_wdata;
  logic                              r_done;

  assign w_fire = s_valid && (r_state == S_LOAD);
  assign w_last = (r_base + BASE_W'(PARALLELISM)) >= BASE_W'(LENGTH);

  // Per-lane element address and in-range mask for the current base.
  for (genvar g = 0; g < PARALLELISM; g++) begin : g_lane
    logic [BASE_W-1:0] w_lane_sum;
    assign w_lane_sum                          = r_base + BASE_W'(g);
    assign w_mask[g]                           = w_lane_sum < BASE_W'(LENGTH);
    assign w_addr[g*ADDR_WIDTH +: ADDR_WIDTH]  = w_lane_sum[ADDR_WIDTH-1:0];
  end

  // State, bank select, pending swap and beat base registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ping  <= 1'b0;
      r_pend  <= 1'b0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ping  <= w_ping_nxt;
      r_pend  <= w_pend_nxt;
      r_base  <= w_base_nxt;
    end
  end

  // Next-state logic: ping may only move in IDLE or when leaving FULL.
  always_comb begin
    w_state_nxt = r_state;
    w_ping_nxt  = r_ping;
    w_pend_nxt  = r_pend;
    w_base_nxt  = r_base;
    case (r_state)
      S_IDLE: begin
        if (swap) w_ping_nxt = ~r_ping;
        if (start) begin
          w_state_nxt = S_LOAD;
          w_base_nxt  = '0;
        end
      end
      S_LOAD: begin
        if (swap) w_pend_nxt = 1'b1;
        if (w_fire) begin
          w_base_nxt = r_base + BASE_W'(PARALLELISM);
          if (w_last) w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (swap || r_pend) begin
          w_ping_nxt  = ~r_ping;
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered cfg write port: one-cycle strobes, address/data held between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_valid <= '0;
      r_cfg_addr  <= '0;
      r_cfg_wdata <= '0;
      r_done      <= 1'b0;
    end else begin
      r_cfg_valid <= w_fire ? w_mask : '0;
      r_done      <= w_fire && w_last;
      if (w_fire) begin
        r_cfg_addr  <= w_addr;
        r_cfg_wdata <= s_data;
      end
    end
  end

  assign s_ready    = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  // The final write is presented in the first FULL cycle, flagged by done.
  assign cfg_en     = (r_state == S_LOAD) || r_done;
  assign cfg_valid  = r_cfg_valid;
  assign cfg_write  = r_cfg_valid;
  assign cfg_rready = '0;
  assign cfg_addr   = r_cfg_addr;
  assign cfg_wdata  = r_cfg_wdata;
  assign ping       = r_ping;
  assign done       = r_done;

endmodule

// File: tb/tb_vector_stream_loader.sv
// Bench for vector_stream_loader (LENGTH=10, PARALLELISM=4, 8-bit elements).
module tb_vector_stream_loader;

  localparam int LENGTH      = 10;
  localparam int DATA_WIDTH  = 8;
  localparam int PARALLELISM = 4;
  localparam int ADDR_WIDTH  = 4;
  localparam int SW          = ADDR_WIDTH + DATA_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start   = 1'b0;
  logic swap    = 1'b0;
  logic s_valid = 1'b0;
  logic [PARALLELISM*DATA_WIDTH-1:0] s_data = '0;

  logic                              s_ready;
  logic                              cfg_en;
  logic [PARALLELISM-1:0]            cfg_valid;
  logic [PARALLELISM-1:0]            cfg_write;
  logic [PARALLELISM-1:0]            cfg_rready;
  logic [PARALLELISM*ADDR_WIDTH-1:0] cfg_addr;
  logic [PARALLELISM*DATA_WIDTH-1:0] cfg_wdata;
  logic                              ping;
  logic                              busy;
  logic                              done;

  always #5 clk = ~clk;

  vector_stream_loader #(
    .LENGTH(LENGTH), .DATA_WIDTH(DATA_WIDTH),
    .PARALLELISM(PARALLELISM), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .swap(swap),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_en(cfg_en), .cfg_valid(cfg_valid), .cfg_write(cfg_write),
    .cfg_rready(cfg_rready), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ping(ping), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 = no vector in progress, 1 = accepting beats, 2 = vector complete.
  int                                m_mode = 0;
  bit                                m_ping = 1'b0;
  bit                                m_pend = 1'b0;
  int                                m_next_elem = 0;
  logic [PARALLELISM-1:0]            e_valid = '0;
  logic [PARALLELISM*ADDR_WIDTH-1:0] e_addr  = '0;
  logic [PARALLELISM*DATA_WIDTH-1:0] e_wdata = '0;
  bit                                e_done  = 1'b0;
  logic [SW-1:0]                     exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    bit fire;
    int a;
    logic [SW-1:0] ent;
    if (!rst_n) begin
      m_mode = 0; m_ping = 0; m_pend = 0; m_next_elem = 0;
      e_valid = '0; e_addr = '0; e_wdata = '0; e_done = 0;
      exp_q.delete();
    end else begin
      fire    = (m_mode == 1) && s_valid;
      e_valid = '0;
      e_done  = 0;
      if (fire) begin
        for (int i = 0; i < PARALLELISM; i++) begin
          a = m_next_elem + i;
          e_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = a[ADDR_WIDTH-1:0];
          e_wdata[i*DATA_WIDTH +: DATA_WIDTH] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
          if (a < LENGTH) begin
            e_valid[i] = 1'b1;
            ent = {a[ADDR_WIDTH-1:0], s_data[i*DATA_WIDTH +: DATA_WIDTH]};
            exp_q.push_back(ent);
          end
        end
      end
      case (m_mode)
        0: begin
          if (swap) m_ping = !m_ping;
          if (start) begin m_mode = 1; m_next_elem = 0; end
        end
        1: begin
          if (swap) m_pend = 1;
          if (fire) begin
            m_next_elem = m_next_elem + PARALLELISM;
            if (m_next_elem >= LENGTH) begin m_mode = 2; e_done = 1; end
          end
        end
        default: begin
          if (swap || m_pend) begin m_ping = !m_ping; m_mode = 0; m_pend = 0; end
        end
      endcase
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    logic [SW-1:0] got;
    chk("s_ready", s_ready, m_mode == 1);
    chk("busy", busy, m_mode != 0);
    chk("cfg_en", cfg_en, (m_mode == 1) || e_done);
    chk("cfg_valid", cfg_valid, e_valid);
    chk("cfg_write", cfg_write, e_valid);
    chk("cfg_rready", cfg_rready, 0);
    chk("cfg_addr", cfg_addr, e_addr);
    chk("cfg_wdata", cfg_wdata, e_wdata);
    chk("done", done, e_done);
    chk("ping", ping, m_ping);
    for (int i = 0; i < PARALLELISM; i++) begin
      if (cfg_valid[i] === 1'b1) begin
        got = {cfg_addr[i*ADDR_WIDTH +: ADDR_WIDTH], cfg_wdata[i*DATA_WIDTH +: DATA_WIDTH]};
        if (exp_q.size() == 0) chk("sb_unexpected_write", got, 0);
        else chk("sb_write", got, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int en_cnt;
    en_cnt = 0;
    // Reset values.
    repeat (2) cyc();
    chk("rst_ping", ping, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_addr", cfg_addr, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc();

    // Three back-to-back beats into a 10-element vector.
    start = 1; en_cnt += cfg_en;
    cyc(); start = 0; s_valid = 1; s_data = 32'h03020100; en_cnt += cfg_en;
    chk("d_ready", s_ready, 1);
    cyc(); s_data = 32'h13121110; en_cnt += cfg_en;
    chk("d_addr0", cfg_addr, 16'h3210);
    chk("d_mask0", cfg_valid, 4'b1111);
    chk("d_done0", done, 0);
    cyc(); s_data = 32'h23222120; en_cnt += cfg_en;
    chk("d_addr1", cfg_addr, 16'h7654);
    chk("d_mask1", cfg_valid, 4'b1111);
    chk("d_wdata1", cfg_wdata, 32'h13121110);
    cyc(); s_valid = 0; en_cnt += cfg_en;
    chk("d_addr2", cfg_addr, 16'hBA98);
    chk("d_mask2", cfg_valid, 4'b0011);
    chk("d_done2", done, 1);
    chk("d_ready_full", s_ready, 0);
    cyc(); en_cnt += cfg_en;
    chk("d_busy_full", busy, 1);
    chk("d_ping_hold", ping, 0);
    // Start while FULL is ignored.
    start = 1;
    cyc(); start = 0; en_cnt += cfg_en;
    chk("full_start_ready", s_ready, 0);
    chk("full_start_busy", busy, 1);
    chk("cfg_en_cycles", en_cnt, 4);

    // Swap in FULL, then swap in IDLE.
    swap = 1;
    cyc(); swap = 0;
    chk("swap_full_ping", ping, 1);
    chk("swap_full_idle", busy, 0);
    swap = 1;
    cyc(); swap = 0;
    chk("swap_idle_ping", ping, 0);
    chk("swap_idle_nowr", cfg_valid, 0);

    // Swap pulsed during LOAD is deferred until FULL.
    start = 1;
    cyc(); start = 0; s_valid = 1; swap = 1; s_data = $urandom;
    cyc(); swap = 0; s_data = $urandom;
    chk("pend_ping_load", ping, 0);
    cyc(); s_data = $urandom;
    cyc(); s_valid = 0;
    chk("pend_ping_done", ping, 0);
    chk("pend_done", done, 1);
    cyc();
    chk("pend_ping_applied", ping, 1);
    chk("pend_idle", busy, 0);

    // Reset after the second of three beats.
    start = 1;
    cyc(); start = 0; s_valid = 1; s_data = $urandom;
    cyc(); s_data = $urandom;
    cyc(); s_valid = 0;
    chk("pre_rst_valid", cfg_valid, 4'b1111);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", cfg_valid, 0);
    chk("arst_en", cfg_en, 0);
    chk("arst_ping", ping, 0);
    chk("arst_addr", cfg_addr, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    #2 rst_n = 1;
    cyc();
    chk("post_rst_idle", s_ready, 0);
    start = 1;
    cyc(); start = 0; s_valid = 1; s_data = 32'h44332211;
    cyc(); s_valid = 0;
    chk("reload_addr", cfg_addr, 16'h3210);
    chk("reload_wdata", cfg_wdata, 32'h44332211);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      start   = ($urandom_range(0, 3) == 0);
      swap    = ($urandom_range(0, 9) == 0);
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = $urandom;
      if (n == 1500) begin
        #2 rst_n = 0;
        #5 rst_n = 1;
      end
    end
    cyc();
    start = 0; swap = 0; s_valid = 0;
    repeat (3) cyc();
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
